// File: rtl/uart_buffers_gen2.sv
// uart_buffers_gen2: UART TX/RX character FIFOs with status, trigger level and sticky overrun.
// Optional character timeout is built when UART_BUF_RX_TIMEOUT_EN is defined.
module uart_buffers_gen2 #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              fifoen,
  input  logic              txclr,
  input  logic              rxclr,
  input  logic [1:0]        rxfiftl,
  input  logic              thr_wr_en,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              tsr_load,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic              tx_empty,
  output logic [CW-1:0]     tx_count,
  input  logic              receive_done,
  input  logic [DATA_W-1:0] rsr_data,
  input  logic              parity_error,
  input  logic              frame_error,
  input  logic              uart_break,
  input  logic              rbr_rd_en,
  output logic [DATA_W+2:0] rbr,
  output logic              rx_full,
  output logic              rx_empty,
  output logic [CW-1:0]     rx_count,
  output logic              dr,
  output logic              rx_trig,
  input  logic              lsr_rd,
  output logic              overrun,
  output logic              rx_err,
  input  logic              char_tick,
  output logic              rx_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 3;
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [EW-1:0]     rx_mem [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, err_q, err_d, cap, lvl;
  logic fifoen_q, ovr_q, ovr_d;
  logic tx_clr, rx_clr, tx_push, tx_pop, rx_push, rx_pop, rx_ovf;
  logic [EW-1:0] rx_in;
  // a mode switch flushes both FIFOs so capacity never drops below occupancy
  assign tx_clr = txclr | (fifoen ^ fifoen_q);
  assign rx_clr = rxclr | (fifoen ^ fifoen_q);
  assign cap = fifoen ? CW'(DEPTH) : CW'(1);
  assign lvl = !fifoen ? CW'(1) :
               rxfiftl == 2'd0 ? CW'(1) :
               rxfiftl == 2'd1 ? CW'(DEPTH / 4) :
               rxfiftl == 2'd2 ? CW'(DEPTH / 2) : CW'(DEPTH - 2);
  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == cap;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == cap;
  assign tx_pop  = tsr_load & ~tx_empty;
  assign tx_push = thr_wr_en & (~tx_full | tx_pop);
  assign rx_pop  = rbr_rd_en & ~rx_empty;
  assign rx_push = receive_done & (~rx_full | rx_pop);
  assign rx_ovf  = receive_done & rx_full & ~rx_pop;
  assign rx_in   = {uart_break, frame_error, parity_error, rsr_data};
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign rbr      = rx_empty ? '0 : rx_mem[rx_rp_q];
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
  assign dr       = ~rx_empty;
  assign rx_trig  = rx_cnt_q >= lvl;
  assign overrun  = ovr_q;
  assign rx_err   = err_q != '0;
  always_comb begin
    tx_wp_d  = tx_clr ? '0 : tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_clr ? '0 : tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_clr ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_clr ? '0 : rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_clr ? '0 : rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_clr ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    err_d    = rx_clr ? '0 : err_q + CW'(rx_push & |rx_in[EW-1:DATA_W]) - CW'(rx_pop & |rbr[EW-1:DATA_W]);
    ovr_d    = rx_ovf | (ovr_q & ~lsr_rd);
  end
  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wp_q] <= pwdata;
    if (rx_push) rx_mem[rx_wp_q] <= rx_in;
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      err_q    <= '0;
      ovr_q    <= 1'b0;
      fifoen_q <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      fifoen_q <= fifoen;
    end
  end
`ifdef UART_BUF_RX_TIMEOUT_EN
  logic [2:0] to_q, to_d;
  always_comb
    to_d = (receive_done | rbr_rd_en | rx_clr | rx_empty) ? 3'd0 :
           (char_tick && to_q != 3'd4) ? to_q + 3'd1 : to_q;
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) to_q <= 3'd0;
    else to_q <= to_d;
  end
  assign rx_timeout = to_q == 3'd4;
`else
  logic unused_char_tick;
  assign unused_char_tick = char_tick;
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_buffers_gen2.sv
// tb_uart_buffers_gen2: directed and random checks of uart_buffers_gen2 against a queue-based model.
module tb_uart_buffers_gen2;
  localparam int DEPTH = 16;
  localparam int DATA_W = 8;
  localparam int CW = 5;
  logic pclk = 0, preset = 0, fifoen = 1, txclr = 0, rxclr = 0;
  logic [1:0] rxfiftl = 0;
  logic thr_wr_en = 0, tsr_load = 0, receive_done = 0, rbr_rd_en = 0;
  logic parity_error = 0, frame_error = 0, uart_break = 0, lsr_rd = 0, char_tick = 0;
  logic [DATA_W-1:0] pwdata = 0, rsr_data = 0;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W+2:0] rbr;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty, dr, rx_trig, overrun, rx_err, rx_timeout;

  uart_buffers_gen2 #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .pclk(pclk), .preset(preset), .fifoen(fifoen), .txclr(txclr), .rxclr(rxclr),
    .rxfiftl(rxfiftl), .thr_wr_en(thr_wr_en), .pwdata(pwdata), .tsr_load(tsr_load),
    .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
    .receive_done(receive_done), .rsr_data(rsr_data), .parity_error(parity_error),
    .frame_error(frame_error), .uart_break(uart_break), .rbr_rd_en(rbr_rd_en),
    .rbr(rbr), .rx_full(rx_full), .rx_empty(rx_empty), .rx_count(rx_count), .dr(dr),
    .rx_trig(rx_trig), .lsr_rd(lsr_rd), .overrun(overrun), .rx_err(rx_err),
    .char_tick(char_tick), .rx_timeout(rx_timeout)
  );

  always #5 pclk = ~pclk;

  int passed = 0, total = 0;
  logic [DATA_W-1:0] txm[$];
  logic [DATA_W+2:0] rxm[$];
  bit m_ovr = 0, m_fen = 0;
  int m_to = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int mcap();
    return fifoen ? DEPTH : 1;
  endfunction

  function automatic int mlvl();
    if (!fifoen) return 1;
    case (rxfiftl)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic model_clk();
    bit chg, tp, tw, rp, rw, rfull, rclr;
    int cap;
    chg = fifoen != m_fen;
    cap = mcap();
    tp = tsr_load && txm.size() > 0;
    tw = thr_wr_en && (txm.size() < cap || tp);
    rp = rbr_rd_en && rxm.size() > 0;
    rfull = rxm.size() == cap;
    rw = receive_done && (!rfull || rp);
    rclr = rxclr || chg;
    m_to = (receive_done || rbr_rd_en || rclr || rxm.size() == 0) ? 0 :
           (char_tick && m_to < 4) ? m_to + 1 : m_to;
    m_ovr = (receive_done && rfull && !rp) || (m_ovr && !lsr_rd);
    if (txclr || chg) txm.delete();
    else begin
      if (tp) void'(txm.pop_front());
      if (tw) txm.push_back(pwdata);
    end
    if (rclr) rxm.delete();
    else begin
      if (rp) void'(rxm.pop_front());
      if (rw) rxm.push_back({uart_break, frame_error, parity_error, rsr_data});
    end
    m_fen = fifoen;
  endtask

  task automatic check_all();
    bit err = 0;
    int cap = mcap();
    foreach (rxm[i]) if (rxm[i][DATA_W+2:DATA_W] != 3'b0) err = 1;
    chk("tx_data", 32'(tx_data), txm.size() > 0 ? 32'(txm[0]) : 32'd0);
    chk("tx_count", 32'(tx_count), 32'(txm.size()));
    chk("tx_full", 32'(tx_full), 32'(txm.size() == cap));
    chk("tx_empty", 32'(tx_empty), 32'(txm.size() == 0));
    chk("rbr", 32'(rbr), rxm.size() > 0 ? 32'(rxm[0]) : 32'd0);
    chk("rx_count", 32'(rx_count), 32'(rxm.size()));
    chk("rx_full", 32'(rx_full), 32'(rxm.size() == cap));
    chk("rx_empty", 32'(rx_empty), 32'(rxm.size() == 0));
    chk("dr", 32'(dr), 32'(rxm.size() != 0));
    chk("rx_trig", 32'(rx_trig), 32'(rxm.size() >= mlvl()));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("rx_err", 32'(rx_err), 32'(err));
`ifdef UART_BUF_RX_TIMEOUT_EN
    chk("rx_timeout", 32'(rx_timeout), 32'(m_to == 4));
`else
    chk("rx_timeout", 32'(rx_timeout), 32'd0);
`endif
  endtask

  task automatic clear_strobes();
    txclr = 0; rxclr = 0; thr_wr_en = 0; tsr_load = 0; receive_done = 0; rbr_rd_en = 0;
    parity_error = 0; frame_error = 0; uart_break = 0; lsr_rd = 0; char_tick = 0;
  endtask

  task automatic step();
    @(posedge pclk);
    model_clk();
    #1;
    check_all();
    clear_strobes();
  endtask

  task automatic do_reset();
    #2 preset = 1;
    #1;
    txm.delete(); rxm.delete(); m_ovr = 0; m_to = 0; m_fen = 0;
    check_all();
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    clear_strobes();
    @(posedge pclk);
    #1 preset = 0;
  endtask

  initial begin
    do_reset();
    step();
    for (int i = 0; i < 16; i++) begin
      thr_wr_en = 1; pwdata = 8'(i); step();
    end
    chk("tx_full16", 32'(tx_full), 32'd1);
    chk("tx_count16", 32'(tx_count), 32'd16);
    thr_wr_en = 1; pwdata = 8'hAA; step();
    chk("tx_17th_drop", 32'(tx_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("tx_order", 32'(tx_data), 32'(i));
      tsr_load = 1; step();
    end
    chk("tx_drained", 32'(tx_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      receive_done = 1; rsr_data = 8'($urandom); step();
    end
    receive_done = 1; step();
    chk("ovr_set", 32'(overrun), 32'd1);
    lsr_rd = 1; step();
    chk("ovr_clr", 32'(overrun), 32'd0);
    receive_done = 1; rbr_rd_en = 1; step();
    chk("full_pushpop_cnt", 32'(rx_count), 32'd16);
    chk("full_pushpop_ovr", 32'(overrun), 32'd0);
    rxclr = 1; step();
    rxfiftl = 2'd1;
    for (int i = 0; i < 3; i++) begin
      receive_done = 1; rsr_data = 8'(i); step();
    end
    chk("trig3", 32'(rx_trig), 32'd0);
    receive_done = 1; step();
    chk("trig4", 32'(rx_trig), 32'd1);
    rbr_rd_en = 1; step();
    chk("trig_pop", 32'(rx_trig), 32'd0);
    rxclr = 1; rxfiftl = 2'd0; step();
    receive_done = 1; rsr_data = 8'h41; parity_error = 1; step();
    chk("rbr_par", 32'(rbr), 32'h141);
    chk("rx_err_set", 32'(rx_err), 32'd1);
    rbr_rd_en = 1; step();
    chk("rx_err_clr", 32'(rx_err), 32'd0);
`ifdef UART_BUF_RX_TIMEOUT_EN
    receive_done = 1; step();
    repeat (3) begin char_tick = 1; step(); end
    chk("to_early", 32'(rx_timeout), 32'd0);
    char_tick = 1; step();
    chk("to_fire", 32'(rx_timeout), 32'd1);
    rbr_rd_en = 1; step();
    chk("to_clr", 32'(rx_timeout), 32'd0);
`endif
    fifoen = 0; step();
    thr_wr_en = 1; pwdata = 8'h11; step();
    thr_wr_en = 1; pwdata = 8'h22; step();
    chk("nf_cnt", 32'(tx_count), 32'd1);
    chk("nf_head", 32'(tx_data), 32'h11);
    receive_done = 1; rsr_data = 8'h33; step();
    thr_wr_en = 1; receive_done = 1;
    do_reset();
    chk("rst_tx_cnt", 32'(tx_count), 32'd0);
    chk("rst_rx_cnt", 32'(rx_count), 32'd0);
    fifoen = 1;
    for (int n = 0; n < 800; n++) begin
      int wp = (n % 200 < 100) ? 60 : 30;
      if ($urandom_range(63) == 0) fifoen = ~fifoen;
      if ($urandom_range(31) == 0) rxfiftl = 2'($urandom);
      thr_wr_en = $urandom_range(99) < wp;
      tsr_load = $urandom_range(99) < 40;
      pwdata = 8'($urandom);
      receive_done = $urandom_range(99) < wp;
      rbr_rd_en = $urandom_range(99) < 35;
      rsr_data = 8'($urandom);
      parity_error = $urandom_range(7) == 0;
      frame_error = $urandom_range(7) == 0;
      uart_break = $urandom_range(15) == 0;
      lsr_rd = $urandom_range(9) == 0;
      char_tick = $urandom_range(1) == 0;
      txclr = $urandom_range(63) == 0;
      rxclr = $urandom_range(63) == 0;
      step();
    end
    thr_wr_en = 1; receive_done = 1; rsr_data = 8'h5A;
    do_reset();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
